// File: rtl/stopwatch_counter.sv
// stopwatch_counter: debounced start/stop/clear(/lap) control and 16-bit seconds counter for the hex display.
// Optional lap-hold display freeze enabled by defining STOPWATCH_LAP_EN.
module stopwatch_counter #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int DB_W            = 18
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        second_toggle,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    input  logic        btn_lap,
    output logic [15:0] four_hex_out,
    output logic        running,
    output logic        overflow,
    output logic        lap_hold
);
`ifdef STOPWATCH_LAP_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
    state_t          state_q, state_d;
    logic            init_q, st_q, st_qq, tick;
    logic [NB-1:0]   btn, s1_q, s2_q, db_q, dbp_q, press;
    logic [DB_W-1:0] dbc_q [NB];
    logic [15:0]     cnt_q, cnt_d, hex_q;
    logic            ovf_q, ovf_d, run_q;
`ifdef STOPWATCH_LAP_EN
    logic [15:0]     lap_val_q, lap_val_d;
    logic            lap_hold_q, lap_hold_d;
    assign btn      = {btn_lap, btn_clear, btn_start_stop};
    assign lap_hold = lap_hold_q;
`else
    logic            unused_lap;
    assign unused_lap = btn_lap;
    assign btn        = {btn_clear, btn_start_stop};
    assign lap_hold   = 1'b0;
`endif
    assign tick         = st_q ^ st_qq;
    assign press        = db_q & ~dbp_q;
    assign four_hex_out = hex_q;
    assign running      = run_q;
    assign overflow     = ovf_q;
    // The first edge after reset loads both stages alike so a stale toggle level is not seen as a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
            st_q   <= 1'b0;
            st_qq  <= 1'b0;
        end else begin
            init_q <= 1'b1;
            st_q   <= second_toggle;
            st_qq  <= init_q ? st_q : second_toggle;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            db_q  <= '0;
            dbp_q <= '0;
            for (int i = 0; i < NB; i++) dbc_q[i] <= '0;
        end else begin
            s1_q  <= btn;
            s2_q  <= s1_q;
            dbp_q <= db_q;
            for (int i = 0; i < NB; i++) begin
                if (s2_q[i] == db_q[i]) begin
                    dbc_q[i] <= '0;
                end else if (dbc_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    dbc_q[i] <= '0;
                    db_q[i]  <= s2_q[i];
                end else begin
                    dbc_q[i] <= dbc_q[i] + 1'b1;
                end
            end
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
`ifdef STOPWATCH_LAP_EN
        lap_val_d  = lap_val_q;
        lap_hold_d = lap_hold_q;
`endif
        case (state_q)
            IDLE:  state_d = press[0] ? RUN : IDLE;
            RUN: begin
                if (tick) begin
                    cnt_d = cnt_q + 16'd1;
                    ovf_d = ovf_q | (cnt_q == 16'hFFFF);
                end
                state_d = press[0] ? PAUSE : RUN;
            end
            PAUSE: state_d = press[0] ? RUN : PAUSE;
            default: state_d = IDLE;
        endcase
`ifdef STOPWATCH_LAP_EN
        if (press[2]) begin
            if (lap_hold_q) begin
                lap_hold_d = 1'b0;
            end else if (state_q == RUN) begin
                lap_val_d  = cnt_q;
                lap_hold_d = 1'b1;
            end
        end
`endif
        if (press[1]) begin
            state_d = IDLE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_hold_d = 1'b0;
`endif
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            hex_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            run_q   <= (state_d == RUN);
`ifdef STOPWATCH_LAP_EN
            hex_q   <= lap_hold_d ? lap_val_d : cnt_d;
`else
            hex_q   <= cnt_d;
`endif
        end
    end
`ifdef STOPWATCH_LAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_val_q  <= '0;
            lap_hold_q <= 1'b0;
        end else begin
            lap_val_q  <= lap_val_d;
            lap_hold_q <= lap_hold_d;
        end
    end
`endif
endmodule
